// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the 5-bit-address MIPS core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the PC,
// IR, register-file, ALU and data-memory strobes, and tracks retired count
// plus halt/illegal status. Strobes are decoded combinationally from the
// state register, the latched opcode, the zero flag and the memory acks.
module mips_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_rd,
    output logic             dmem_we,
    output logic             pc_rst,
    output logic             pc_ld,
    output logic             pc_src,
    output logic             pc_jmp,
    output logic             ir_ld,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t           state;
    state_t           nextState;
    logic [5:0]       opQ;
    logic             illegalQ;
    logic [CNT_W-1:0] retiredQ;
    logic             setIllegal;
    logic             enterHalt;

    assign illegal = illegalQ;
    assign retired = retiredQ;

    // Strobe decode and next-state selection for the current state.
    always_comb begin
        nextState  = state;
        imem_req   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_we    = 1'b0;
        pc_rst     = 1'b0;
        pc_ld      = 1'b0;
        pc_src     = 1'b0;
        pc_jmp     = 1'b0;
        ir_ld      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        halted     = 1'b0;
        setIllegal = 1'b0;
        enterHalt  = 1'b0;
        case (state)
            S_RST: begin
                pc_rst    = 1'b1;
                nextState = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_ld     = 1'b1;
                    nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opQ)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: nextState = S_EXEC;
                    OP_J: begin
                        pc_ld     = 1'b1;
                        pc_jmp    = 1'b1;
                        nextState = S_FETCH;
                    end
                    OP_HALT: begin
                        enterHalt = 1'b1;
                        nextState = S_HALT;
                    end
                    default: begin
                        // Unknown opcodes are skipped with a plain sequential advance.
                        setIllegal = 1'b1;
                        pc_ld      = 1'b1;
                        nextState  = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (opQ)
                    OP_RTYPE: begin
                        alu_op    = 3'b010;
                        nextState = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src   = 1'b1;
                        nextState = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src   = 1'b1;
                        nextState = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op    = 3'b001;
                        pc_ld     = 1'b1;
                        pc_src    = zero;
                        nextState = S_FETCH;
                    end
                    default: nextState = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Address operands stay selected for the whole access.
                alu_src = 1'b1;
                if (opQ == OP_LW) begin
                    dmem_rd = 1'b1;
                    if (dmem_ack) nextState = S_WB;
                end else begin
                    dmem_we = 1'b1;
                    if (dmem_ack) begin
                        pc_ld     = 1'b1;
                        nextState = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_ld      = 1'b1;
                reg_dst    = (opQ == OP_RTYPE);
                mem_to_reg = (opQ == OP_LW);
                nextState  = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: nextState = S_RST;
        endcase
    end

    // State, latched opcode, sticky illegal flag and retired counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RST;
            opQ      <= 6'b000000;
            illegalQ <= 1'b0;
            retiredQ <= '0;
        end else begin
            state <= nextState;
            if (ir_ld) opQ <= opcode;
            if (setIllegal) illegalQ <= 1'b1;
            if (pc_ld || enterHalt) retiredQ <= retiredQ + CNT_W'(1);
        end
    end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control FSM for the 5-bit-address MIPS core. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives the program counter's reset, load, branch-select and jump controls, plus the instruction-register, register-file, ALU and data-memory strobes. It handshakes with instruction and data memory, and keeps a retired-instruction count and halt/illegal status.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from instruction-memory read data; sampled on fetch acknowledge
- zero  in  1  ALU zero flag; sampled combinationally in EXEC
- imem_ack  in  1  instruction-memory acknowledge
- dmem_ack  in  1  data-memory acknowledge
- imem_req  out  1  instruction fetch request
- dmem_rd / dmem_we  out  1 each  data-memory read / write request
- pc_rst  out  1  to PC counterRst (synchronous clear)
- pc_ld  out  1  to PC counterLd
- pc_src  out  1  to PC pcSrc (take branch)
- pc_jmp  out  1  to PC jmp
- ir_ld  out  1  load instruction register
- reg_we  out  1  register-file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  write-back source is memory
- alu_src  out  1  1 = sign-extended immediate
- alu_op  out  3  000 add, 001 sub, 010 decode funct
- halted  out  1  core stopped
- illegal  out  1  sticky; unknown opcode seen
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. rst forces RST.
- RST: pc_rst=1 for exactly one cycle, then FETCH.
- FETCH:
  - imem_req=1 until imem_ack.
  - On the ack cycle: ir_ld=1, opcode latched into op_q, next state DECODE.
  - Ack in the same cycle as the first request gives a 1-cycle fetch.
- DECODE, by op_q:
  - 000000 R-type, 001000 addi, 100011 lw, 101011 sw, 000100 beq: go to EXEC.
  - 000010 j: pc_ld=1, pc_jmp=1; go to FETCH.
  - 111111 halt: go to HALT; no pc_ld.
  - Any other opcode: illegal set, pc_ld=1 (sequential advance); go to FETCH.
- EXEC:
  - R-type: alu_op=010, go to WB.
  - addi: alu_op=000, alu_src=1, go to WB.
  - lw / sw: alu_op=000, alu_src=1, go to MEM.
  - beq: alu_op=001, pc_ld=1, pc_src=zero; go to FETCH.
- MEM:
  - lw: dmem_rd=1 until dmem_ack, then WB.
  - sw: dmem_we=1 until dmem_ack; on the ack cycle pc_ld=1, then FETCH.
  - alu_op=000 and alu_src=1 are held throughout MEM so the address stays stable.
- WB: reg_we=1 and pc_ld=1; go to FETCH.
  - R-type: reg_dst=1.
  - addi: reg_dst=0.
  - lw: reg_dst=0, mem_to_reg=1.
- HALT: halted=1, all other strobes 0; remains until rst.
- retired:
  - Increments in every cycle where pc_ld=1, and once on entry to HALT.
  - Illegal opcodes count as retired.
- Acks arriving in a state that is not requesting are ignored.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational decodes of the state register, op_q, zero and the acks.
- State, op_q, illegal and retired are registered.
- Reset values, asynchronous and effective immediately:
  - state=RST, so pc_rst=1.
  - All other strobes 0, halted=0, illegal=0, retired=0, op_q=0.
- Cycle counts with zero-wait-state acks:
  - R-type / addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 2 cycles.
- Each wait cycle on an ack adds one cycle.
- pc_ld is asserted in exactly one cycle per instruction. The PC updates on the edge closing that cycle, so the next FETCH sees the new PC.
- pc_src and pc_jmp are never both 1, and are 0 whenever pc_ld=0.
- rst asserted mid-instruction (for example while waiting on dmem_ack) aborts it immediately:
  - No reg_we or pc_ld is issued.
  - After rst deasserts, RST restarts the core at PC 0.

## Test plan
- Reset, then R-type (op 000000) with immediate acks:
  - pc_rst=1 for one cycle.
  - Sequence FETCH, DECODE, EXEC, WB.
  - In WB: reg_we=1, reg_dst=1, pc_ld=1; retired=1.
- lw with dmem_ack delayed 3 cycles:
  - dmem_rd held for 4 cycles.
  - WB asserts mem_to_reg=1, reg_we=1.
  - Total 8 cycles; pc_ld asserted exactly once.
- beq run twice:
  - zero=1 gives pc_ld=1, pc_src=1 in EXEC.
  - zero=0 gives pc_src=0.
  - No reg_we in either case.
- j followed by opcode 010101:
  - j: pc_jmp=1 in DECODE, 2 cycles total.
  - Unknown opcode: illegal goes to 1 and stays 1; pc_ld=1 with pc_src=0 and pc_jmp=0; retired=2.
- halt:
  - halted=1 from the cycle after DECODE.
  - imem_req stays 0 for 20 cycles; retired increments by exactly 1.
- rst pulsed while sw is waiting on dmem_ack:
  - dmem_we drops immediately; no pc_ld.
  - retired=0, illegal=0.
  - pc_rst=1 in the first cycle after rst deasserts.
